score_keeper: RTL

Downstream consumer of the game core's line-clear and game-over events. Counts rows removed per clearing sequence and converts them into a 4-digit BCD score with a combo bonus. Tracks total lines and a 0–9 level, which feeds the control block's auto-drop speed. Drives a 4-digit multiplexed common-anode 7-segment display with the score, blinking it after game over.

---
 rtl/score_keeper.sv | 130 +++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper: BCD score with combo bonus, line/level tracking and a blinking
// multiplexed 7-segment score display.
module score_keeper #(
  parameter int SCAN_DIV        = 100000,
  parameter int LINES_PER_LEVEL = 10,
  parameter int BLINK_SCANS     = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        remove,
  input  logic        remove_finish,
  input  logic        die,
  input  logic        start,
  output logic [15:0] score,
  output logic [3:0]  level,
  output logic        game_over,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_SCANS > 1 ? $clog2(BLINK_SCANS) : 1;
  logic          remove_q, start_q;
  logic [2:0]    rows_q, rows_d;
  logic [15:0]   score_q, score_d;
  logic [9:0]    lines_q, lines_d;
  logic [3:0]    level_q, level_d;
  logic [4:0]    lvl_q, lvl_d;
  logic          go_q, go_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          blank_q, blank_d;
  logic          rem_e, st_e, commit, wrap, round;
  logic [3:0]    rows_tot, bonus, nib;
  logic [2:0]    rows;
  logic [4:0]    c, t;
  logic [15:0]   sum;
  logic [10:0]   lsum;
  logic [5:0]    csum, cnx;
  always_comb begin
    rem_e    = remove & ~remove_q & ~go_q;
    st_e     = start & ~start_q;
    commit   = remove_finish & ~go_q;
    rows_tot = {1'b0, rows_q} + {3'b0, rem_e};
    rows     = rows_tot > 4'd4 ? 3'd4 : rows_tot[2:0];
    bonus    = rows == 3'd0 ? 4'd0 : rows == 3'd1 ? 4'd1 : rows == 3'd2 ? 4'd3 :
               rows == 3'd3 ? 4'd5 : 4'd8;
    c   = {1'b0, bonus};
    sum = '0;
    t   = '0;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, score_q[4*i +: 4]} + c;
      sum[4*i +: 4] = t > 5'd9 ? 4'(t - 5'd10) : t[3:0];
      c = t > 5'd9 ? 5'd1 : 5'd0;
    end
    lsum = {1'b0, lines_q} + {8'b0, rows};
    csum = {1'b0, lvl_q} + {3'b0, rows};
    // Only one level step per commit; any excess remainder carries forward.
    cnx  = csum >= 6'(LINES_PER_LEVEL) ? csum - 6'(LINES_PER_LEVEL) : csum;
    rows_d  = commit ? 3'd0 : rem_e && rows_q != 3'd4 ? rows_q + 3'd1 : rows_q;
    score_d = commit ? (c != 5'd0 ? 16'h9999 : sum) : score_q;
    lines_d = commit ? (lsum > 11'd999 ? 10'd999 : lsum[9:0]) : lines_q;
    lvl_d   = commit ? (cnx > 6'd31 ? 5'd31 : cnx[4:0]) : lvl_q;
    level_d = commit && csum >= 6'(LINES_PER_LEVEL) && level_q != 4'd9 ? level_q + 4'd1 : level_q;
    go_d    = go_q | die;
    if (st_e) begin
      rows_d  = '0;
      score_d = '0;
      lines_d = '0;
      lvl_d   = '0;
      level_d = '0;
      go_d    = 1'b0;
    end
    wrap    = scan_q == SW'(SCAN_DIV - 1);
    scan_d  = wrap ? '0 : scan_q + 1'b1;
    idx_d   = idx_q + {1'b0, wrap};
    round   = wrap && idx_q == 2'd3;
    blink_d = !go_q ? '0 : round ? (blink_q == BW'(BLINK_SCANS - 1) ? '0 : blink_q + 1'b1) : blink_q;
    blank_d = !go_q ? 1'b0 : round && blink_q == BW'(BLINK_SCANS - 1) ? ~blank_q : blank_q;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      remove_q <= 1'b0;
      start_q  <= 1'b0;
      rows_q   <= '0;
      score_q  <= '0;
      lines_q  <= '0;
      lvl_q    <= '0;
      level_q  <= '0;
      go_q     <= 1'b0;
      scan_q   <= '0;
      idx_q    <= '0;
      blink_q  <= '0;
      blank_q  <= 1'b0;
    end else begin
      remove_q <= remove;
      start_q  <= start;
      rows_q   <= rows_d;
      score_q  <= score_d;
      lines_q  <= lines_d;
      lvl_q    <= lvl_d;
      level_q  <= level_d;
      go_q     <= go_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      blank_q  <= blank_d;
    end
  end
  always_comb begin
    nib = score_q[4*idx_q +: 4];
    an  = go_q && blank_q ? 4'b1111 : ~(4'b0001 << idx_q);
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
  assign score     = score_q;
  assign level     = level_q;
  assign game_over = go_q;
endmodule
